mc_control: RTL and testbench

Multi-cycle control unit for the SCCPU datapath. It walks each instruction through fetch / decode / execute / memory / write-back states and drives the function-select code consumed by the shared 32-bit ALU, plus the datapath mux selects and write enables. It also runs a req/ack handshake with a single shared instruction/data memory port.

---
 rtl/mc_control.sv | 267 ++++++++++++++++++++++++++
 tb/tb_mc_control.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control.sv
`default_nettype none
// ============================================================================
//  Module   : mc_control
//  Purpose  : Multi-cycle control unit for the SCCPU datapath. Sequences each
//             instruction through IF / ID / EXE / MEM / WB and drives the ALU
//             function code, datapath mux selects, write enables and the
//             req/ack handshake of the shared instruction/data memory port.
//  Ports    : clk, clrn (sync active-low reset)
//             op, func      instruction fields IR[31:26], IR[5:0]
//             z             ALU zero flag
//             mem_ack       memory completes the current request this cycle
//             mem_req, iord, wmem           memory port control
//             irwr, pcwr, pcsource          IR / PC update control
//             aluc, alusrca, alusrcb, sext  ALU control
//             wreg, regdst, m2reg, jal      register-file write control
//             ill           one-cycle pulse on an undecodable instruction
//             state         current FSM state (debug)
//  Revision : 1.0  initial release
// ============================================================================
module mc_control (
  input  logic       clk,
  input  logic       clrn,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       z,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       iord,
  output logic       wmem,
  output logic       irwr,
  output logic       pcwr,
  output logic [1:0] pcsource,
  output logic [3:0] aluc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic       sext,
  output logic       wreg,
  output logic [1:0] regdst,
  output logic       m2reg,
  output logic       jal,
  output logic       ill,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_LUI = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1111;

  state_t cur_state;
  state_t nxt_state;

  // --------------------------------------------------------------------------
  // Instruction decode
  // --------------------------------------------------------------------------
  logic is_rtype;
  logic is_radd, is_rsub, is_rand, is_ror, is_rxor;
  logic is_sll, is_srl, is_sra, is_jr;
  logic is_shift, is_ralu;
  logic is_addi, is_andi, is_ori, is_xori, is_lui;
  logic is_lw, is_sw, is_beq, is_bne, is_j, is_jal;
  logic is_ialu, legal;
  logic [3:0] aluc_r;
  logic [3:0] aluc_i;

  assign is_rtype = (op == 6'b000000);
  assign is_radd  = is_rtype && (func == 6'b100000);
  assign is_rsub  = is_rtype && (func == 6'b100010);
  assign is_rand  = is_rtype && (func == 6'b100100);
  assign is_ror   = is_rtype && (func == 6'b100101);
  assign is_rxor  = is_rtype && (func == 6'b100110);
  assign is_sll   = is_rtype && (func == 6'b000000);
  assign is_srl   = is_rtype && (func == 6'b000010);
  assign is_sra   = is_rtype && (func == 6'b000011);
  assign is_jr    = is_rtype && (func == 6'b001000);
  assign is_shift = is_sll | is_srl | is_sra;
  assign is_ralu  = is_radd | is_rsub | is_rand | is_ror | is_rxor | is_shift;

  assign is_addi  = (op == 6'b001000);
  assign is_andi  = (op == 6'b001100);
  assign is_ori   = (op == 6'b001101);
  assign is_xori  = (op == 6'b001110);
  assign is_lui   = (op == 6'b001111);
  assign is_lw    = (op == 6'b100011);
  assign is_sw    = (op == 6'b101011);
  assign is_beq   = (op == 6'b000100);
  assign is_bne   = (op == 6'b000101);
  assign is_j     = (op == 6'b000010);
  assign is_jal   = (op == 6'b000011);
  assign is_ialu  = is_addi | is_andi | is_ori | is_xori | is_lui;

  assign legal = is_ralu | is_jr | is_ialu | is_lw | is_sw |
                 is_beq | is_bne | is_j | is_jal;

  always_comb begin
    aluc_r = ALU_ADD;
    case (func)
      6'b100010: aluc_r = ALU_SUB;
      6'b100100: aluc_r = ALU_AND;
      6'b100101: aluc_r = ALU_OR;
      6'b100110: aluc_r = ALU_XOR;
      6'b000000: aluc_r = ALU_SLL;
      6'b000010: aluc_r = ALU_SRL;
      6'b000011: aluc_r = ALU_SRA;
      default:   aluc_r = ALU_ADD;
    endcase
  end

  always_comb begin
    aluc_i = ALU_ADD;
    case (op)
      6'b001100: aluc_i = ALU_AND;
      6'b001101: aluc_i = ALU_OR;
      6'b001110: aluc_i = ALU_XOR;
      6'b001111: aluc_i = ALU_LUI;
      default:   aluc_i = ALU_ADD;
    endcase
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!clrn) begin
      cur_state <= S_IF;
    end else begin
      cur_state <= nxt_state;
    end
  end

  assign state = cur_state;

  // --------------------------------------------------------------------------
  // Next state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    nxt_state = cur_state;
    mem_req   = 1'b0;
    iord      = 1'b0;
    wmem      = 1'b0;
    irwr      = 1'b0;
    pcwr      = 1'b0;
    pcsource  = 2'b00;
    aluc      = ALU_ADD;
    alusrca   = 2'b00;
    alusrcb   = 2'b00;
    sext      = 1'b0;
    wreg      = 1'b0;
    regdst    = 2'b00;
    m2reg     = 1'b0;
    jal       = 1'b0;
    ill       = 1'b0;

    if (!clrn) begin
      // While reset is held the outputs already look like an idle fetch, but
      // mem_ack is ignored so no write enable can fire (this also drops any
      // access that was in flight).
      mem_req   = 1'b1;
      alusrcb   = 2'b01;
      nxt_state = S_IF;
    end else begin
      case (cur_state)
        S_IF: begin
          // PC + 4 is computed every fetch cycle; committed only on ack.
          mem_req = 1'b1;
          alusrcb = 2'b01;
          if (mem_ack) begin
            irwr      = 1'b1;
            pcwr      = 1'b1;
            nxt_state = S_ID;
          end
        end

        S_ID: begin
          // Branch target PC + (sext(imm) << 2) is always precomputed here.
          alusrcb = 2'b11;
          sext    = 1'b1;
          if (!legal) begin
            ill       = 1'b1;
            nxt_state = S_IF;
          end else if (is_j) begin
            pcwr      = 1'b1;
            pcsource  = 2'b10;
            nxt_state = S_IF;
          end else if (is_jal) begin
            pcwr      = 1'b1;
            pcsource  = 2'b10;
            wreg      = 1'b1;
            regdst    = 2'b10;
            jal       = 1'b1;
            nxt_state = S_IF;
          end else if (is_jr) begin
            pcwr      = 1'b1;
            pcsource  = 2'b11;
            nxt_state = S_IF;
          end else begin
            nxt_state = S_EXE;
          end
        end

        S_EXE: begin
          if (is_rtype) begin
            alusrca   = is_shift ? 2'b10 : 2'b01;
            alusrcb   = 2'b00;
            aluc      = aluc_r;
            nxt_state = S_WB;
          end else if (is_ialu) begin
            alusrca   = 2'b01;
            alusrcb   = 2'b10;
            sext      = is_addi;
            aluc      = aluc_i;
            nxt_state = S_WB;
          end else if (is_lw || is_sw) begin
            alusrca   = 2'b01;
            alusrcb   = 2'b10;
            sext      = 1'b1;
            aluc      = ALU_ADD;
            nxt_state = S_MEM;
          end else begin
            // beq / bne: compare rs - rt, target sits in ALUout from ID.
            alusrca   = 2'b01;
            alusrcb   = 2'b00;
            aluc      = ALU_SUB;
            pcsource  = 2'b01;
            pcwr      = is_beq ? z : (is_bne & ~z);
            nxt_state = S_IF;
          end
        end

        S_MEM: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          wmem    = is_sw;
          if (mem_ack) begin
            nxt_state = is_lw ? S_WB : S_IF;
          end
        end

        S_WB: begin
          wreg      = 1'b1;
          regdst    = is_rtype ? 2'b01 : 2'b00;
          m2reg     = is_lw;
          nxt_state = S_IF;
        end

        default: begin
          nxt_state = S_IF;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mc_control.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mc_control
//  Purpose  : Scoreboard bench for mc_control. A driver walks randomized and
//             directed instructions through the FSM and, for every cycle,
//             pushes the output bundle expected from the instruction-level
//             reference model; a monitor pops and compares each cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mc_control;

  logic       clk;
  logic       clrn;
  logic [5:0] op;
  logic [5:0] func;
  logic       z;
  logic       mem_ack;
  logic       mem_req, iord, wmem, irwr, pcwr;
  logic [1:0] pcsource;
  logic [3:0] aluc;
  logic [1:0] alusrca, alusrcb;
  logic       sext, wreg;
  logic [1:0] regdst;
  logic       m2reg, jal, ill;
  logic [2:0] state;

  mc_control dut (
    .clk(clk), .clrn(clrn), .op(op), .func(func), .z(z), .mem_ack(mem_ack),
    .mem_req(mem_req), .iord(iord), .wmem(wmem), .irwr(irwr), .pcwr(pcwr),
    .pcsource(pcsource), .aluc(aluc), .alusrca(alusrca), .alusrcb(alusrcb),
    .sext(sext), .wreg(wreg), .regdst(regdst), .m2reg(m2reg), .jal(jal),
    .ill(ill), .state(state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [2:0] st;
    logic       mem_req;
    logic       iord;
    logic       wmem;
    logic       irwr;
    logic       pcwr;
    logic [1:0] pcsource;
    logic [3:0] aluc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic       sext;
    logic       wreg;
    logic [1:0] regdst;
    logic       m2reg;
    logic       jal;
    logic       ill;
  } outs_t;

  // Instruction classes of the reference model
  localparam int K_R   = 0;  // R-type ALU, non-shift
  localparam int K_SH  = 1;  // R-type shift
  localparam int K_JR  = 2;
  localparam int K_I   = 3;  // immediate ALU
  localparam int K_LW  = 4;
  localparam int K_SW  = 5;
  localparam int K_BEQ = 6;
  localparam int K_BNE = 7;
  localparam int K_J   = 8;
  localparam int K_JAL = 9;
  localparam int K_ILL = 10;

  localparam int NLEG = 20;
  logic [5:0] t_op   [NLEG];
  logic [5:0] t_func [NLEG];
  int         t_kind [NLEG];
  logic [3:0] t_aluc [NLEG];
  logic       t_sx   [NLEG];

  outs_t sb[$];
  int    checks   = 0;
  int    failures = 0;

  // --------------------------------------------------------------------------
  // Monitor: every cycle the DUT presents a control bundle; compare it with
  // the oldest expectation.
  // --------------------------------------------------------------------------
  outs_t m_exp, m_act;
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      m_exp = sb.pop_front();
      m_act.st       = state;
      m_act.mem_req  = mem_req;
      m_act.iord     = iord;
      m_act.wmem     = wmem;
      m_act.irwr     = irwr;
      m_act.pcwr     = pcwr;
      m_act.pcsource = pcsource;
      m_act.aluc     = aluc;
      m_act.alusrca  = alusrca;
      m_act.alusrcb  = alusrcb;
      m_act.sext     = sext;
      m_act.wreg     = wreg;
      m_act.regdst   = regdst;
      m_act.m2reg    = m2reg;
      m_act.jal      = jal;
      m_act.ill      = ill;
      checks++;
      if (m_act !== m_exp) begin
        failures++;
        $display("FAIL outputs t=%0t op=%b func=%b actual=%h required=%h (st %0d vs %0d)",
                 $time, op, func, m_act, m_exp, m_act.st, m_exp.st);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Reference model: expected bundle per phase of an instruction
  // --------------------------------------------------------------------------
  function automatic outs_t f_if(input logic ack);
    outs_t e = '0;
    e.st = 3'd0; e.mem_req = 1'b1; e.alusrcb = 2'b01;
    e.irwr = ack; e.pcwr = ack;
    return e;
  endfunction

  function automatic outs_t f_id(input int k);
    outs_t e = '0;
    e.st = 3'd1; e.alusrcb = 2'b11; e.sext = 1'b1;
    case (k)
      K_J:   begin e.pcwr = 1'b1; e.pcsource = 2'b10; end
      K_JAL: begin e.pcwr = 1'b1; e.pcsource = 2'b10; e.wreg = 1'b1;
                   e.regdst = 2'b10; e.jal = 1'b1; end
      K_JR:  begin e.pcwr = 1'b1; e.pcsource = 2'b11; end
      K_ILL: e.ill = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  function automatic outs_t f_exe(input int k, input logic [3:0] ac,
                                  input logic sx, input logic zz);
    outs_t e = '0;
    e.st = 3'd2;
    case (k)
      K_R:  begin e.alusrca = 2'b01; e.aluc = ac; end
      K_SH: begin e.alusrca = 2'b10; e.aluc = ac; end
      K_I:  begin e.alusrca = 2'b01; e.alusrcb = 2'b10; e.sext = sx; e.aluc = ac; end
      K_LW, K_SW: begin e.alusrca = 2'b01; e.alusrcb = 2'b10; e.sext = 1'b1; end
      K_BEQ, K_BNE: begin
        e.alusrca = 2'b01; e.aluc = 4'b0100; e.pcsource = 2'b01;
        e.pcwr = (k == K_BEQ) ? zz : ~zz;
      end
      default: ;
    endcase
    return e;
  endfunction

  function automatic outs_t f_mem(input int k);
    outs_t e = '0;
    e.st = 3'd3; e.mem_req = 1'b1; e.iord = 1'b1; e.wmem = (k == K_SW);
    return e;
  endfunction

  function automatic outs_t f_wb(input int k);
    outs_t e = '0;
    e.st = 3'd4; e.wreg = 1'b1;
    e.regdst = (k == K_R || k == K_SH) ? 2'b01 : 2'b00;
    e.m2reg  = (k == K_LW);
    return e;
  endfunction

  function automatic int find(input logic [5:0] o, input logic [5:0] f);
    for (int i = 0; i < NLEG; i++)
      if (t_op[i] == o && (o != 6'd0 || t_func[i] == f)) return i;
    return -1;
  endfunction

  // --------------------------------------------------------------------------
  // Driver
  // --------------------------------------------------------------------------
  task automatic step(input logic cl, input logic ack, input logic [5:0] o,
                      input logic [5:0] f, input logic zz, input outs_t e);
    @(posedge clk);
    #1;
    clrn = cl; mem_ack = ack; op = o; func = f; z = zz;
    sb.push_back(e);
  endtask

  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int k,
                           input logic [3:0] ac, input logic sx, input logic zz,
                           input int wif, input int wm);
    for (int i = 0; i < wif; i++)
      step(1'b1, 1'b0, 6'($urandom), 6'($urandom), 1'($urandom), f_if(1'b0));
    step(1'b1, 1'b1, 6'($urandom), 6'($urandom), 1'($urandom), f_if(1'b1));
    step(1'b1, 1'($urandom), o, f, 1'($urandom), f_id(k));
    if (k == K_J || k == K_JAL || k == K_JR || k == K_ILL) return;
    step(1'b1, 1'($urandom), o, f, zz, f_exe(k, ac, sx, zz));
    if (k == K_BEQ || k == K_BNE) return;
    if (k == K_LW || k == K_SW) begin
      for (int i = 0; i < wm; i++)
        step(1'b1, 1'b0, o, f, 1'($urandom), f_mem(k));
      step(1'b1, 1'b1, o, f, 1'($urandom), f_mem(k));
      if (k == K_SW) return;
    end
    step(1'b1, 1'($urandom), o, f, 1'($urandom), f_wb(k));
  endtask

  task automatic run_idx(input int i, input logic zz, input int wif, input int wm);
    run_instr(t_op[i], t_func[i], t_kind[i], t_aluc[i], t_sx[i], zz, wif, wm);
  endtask

  task automatic add_leg(input int i, input logic [5:0] o, input logic [5:0] f,
                         input int k, input logic [3:0] ac, input logic sx);
    t_op[i] = o; t_func[i] = f; t_kind[i] = k; t_aluc[i] = ac; t_sx[i] = sx;
  endtask

  outs_t e_rst;

  initial begin
    add_leg( 0, 6'b000000, 6'b100000, K_R,   4'b0000, 1'b0);
    add_leg( 1, 6'b000000, 6'b100010, K_R,   4'b0100, 1'b0);
    add_leg( 2, 6'b000000, 6'b100100, K_R,   4'b0001, 1'b0);
    add_leg( 3, 6'b000000, 6'b100101, K_R,   4'b0101, 1'b0);
    add_leg( 4, 6'b000000, 6'b100110, K_R,   4'b0010, 1'b0);
    add_leg( 5, 6'b000000, 6'b000000, K_SH,  4'b0011, 1'b0);
    add_leg( 6, 6'b000000, 6'b000010, K_SH,  4'b0111, 1'b0);
    add_leg( 7, 6'b000000, 6'b000011, K_SH,  4'b1111, 1'b0);
    add_leg( 8, 6'b000000, 6'b001000, K_JR,  4'b0000, 1'b0);
    add_leg( 9, 6'b001000, 6'b000000, K_I,   4'b0000, 1'b1);
    add_leg(10, 6'b001100, 6'b000000, K_I,   4'b0001, 1'b0);
    add_leg(11, 6'b001101, 6'b000000, K_I,   4'b0101, 1'b0);
    add_leg(12, 6'b001110, 6'b000000, K_I,   4'b0010, 1'b0);
    add_leg(13, 6'b001111, 6'b000000, K_I,   4'b0110, 1'b0);
    add_leg(14, 6'b100011, 6'b000000, K_LW,  4'b0000, 1'b0);
    add_leg(15, 6'b101011, 6'b000000, K_SW,  4'b0000, 1'b0);
    add_leg(16, 6'b000100, 6'b000000, K_BEQ, 4'b0000, 1'b0);
    add_leg(17, 6'b000101, 6'b000000, K_BNE, 4'b0000, 1'b0);
    add_leg(18, 6'b000010, 6'b000000, K_J,   4'b0000, 1'b0);
    add_leg(19, 6'b000011, 6'b000000, K_JAL, 4'b0000, 1'b0);

    // Reset held two cycles with ack high: no write enable may fire.
    clrn = 1'b0; mem_ack = 1'b1; op = 6'd0; func = 6'd0; z = 1'b0;
    step(1'b0, 1'b1, 6'd0, 6'd0, 1'b0, f_if(1'b0));
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 6'($urandom), 6'($urandom), 1'b0, f_if(1'b0));

    // Directed cases
    run_idx(0,  1'b0, 0, 0);                        // add
    run_idx(7,  1'b0, 0, 0);                        // sra
    run_idx(13, 1'b0, 0, 0);                        // lui
    run_idx(14, 1'b0, 0, 2);                        // lw, 2 wait cycles
    run_idx(16, 1'b1, 0, 0);                        // beq taken
    run_idx(17, 1'b1, 0, 0);                        // bne not taken
    run_idx(19, 1'b0, 0, 0);                        // jal
    run_instr(6'b111111, 6'd0, K_ILL, 4'd0, 1'b0, 1'b0, 0, 0);
    run_idx(15, 1'b0, 1, 1);                        // sw with waits
    run_idx(8,  1'b0, 0, 0);                        // jr
    run_idx(18, 1'b0, 2, 0);                        // j, fetch waits
    run_instr(6'b000000, 6'b001001, K_ILL, 4'd0, 1'b0, 1'b0, 0, 0);

    // Randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) != 0) begin
        run_idx(int'($urandom_range(0, NLEG - 1)), 1'($urandom),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      end else begin
        logic [5:0] o, f;
        o = 6'($urandom); f = 6'($urandom);
        while (find(o, f) >= 0) begin
          o = 6'($urandom); f = 6'($urandom);
        end
        run_instr(o, f, K_ILL, 4'd0, 1'b0, 1'b0, int'($urandom_range(0, 1)), 0);
      end
    end

    // Reset in the middle of a MEM wait: the access is abandoned.
    step(1'b1, 1'b1, 6'd0, 6'd0, 1'b0, f_if(1'b1));
    step(1'b1, 1'b0, t_op[14], 6'd0, 1'b0, f_id(K_LW));
    step(1'b1, 1'b0, t_op[14], 6'd0, 1'b0, f_exe(K_LW, 4'd0, 1'b0, 1'b0));
    step(1'b1, 1'b0, t_op[14], 6'd0, 1'b0, f_mem(K_LW));
    e_rst = f_if(1'b0);
    e_rst.st = 3'd3;                                // register not yet cleared
    step(1'b0, 1'b1, t_op[14], 6'd0, 1'b0, e_rst);
    step(1'b1, 1'b0, t_op[14], 6'd0, 1'b0, f_if(1'b0));
    run_idx(3, 1'b0, 0, 0);                         // or, after recovery

    repeat (2) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
